// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared encodings for the EX-stage ALU and its multiply/divide unit:
//   - alu_type codes produced by the main decoder
//   - R-type func codes recognised in EX
//   - alu_op codes reported on the alu_op output
//   - mdu_state_t, the state of the iterative multiply/divide FSM
// ----------------------------------------------------------------------------
package alu_pkg;

   // alu_type field from the main decoder
   localparam logic [1:0] ALU_TYPE_ADD   = 2'b00;  // lw / sw / addi
   localparam logic [1:0] ALU_TYPE_SUB   = 2'b01;  // beq / bne
   localparam logic [1:0] ALU_TYPE_RTYPE = 2'b10;  // decode by func
   localparam logic [1:0] ALU_TYPE_AND   = 2'b11;  // andi

   // R-type func field
   localparam logic [5:0] FUNC_ADD   = 6'b100000;
   localparam logic [5:0] FUNC_SUB   = 6'b100010;
   localparam logic [5:0] FUNC_SLT   = 6'b101010;
   localparam logic [5:0] FUNC_SLTU  = 6'b101011;
   localparam logic [5:0] FUNC_AND   = 6'b100100;
   localparam logic [5:0] FUNC_OR    = 6'b100101;
   localparam logic [5:0] FUNC_XOR   = 6'b100110;
   localparam logic [5:0] FUNC_NOR   = 6'b100111;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;
   localparam logic [5:0] FUNC_MFHI  = 6'b010000;
   localparam logic [5:0] FUNC_MFLO  = 6'b010010;

   // Decoded ALU operation
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_SLTU = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

endpackage

// File: rtl/alu_exec_unit_mdu_iter.sv
// ----------------------------------------------------------------------------
// mdu_iter
// Iterative unsigned multiply / divide unit with HI/LO result registers.
// One shift-add (multu) or restoring shift-subtract (divu) step per cycle,
// WIDTH steps per operation, then a single DONE cycle before IDLE.
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   start      begin an operation (only honoured in IDLE)
//   is_div     1 = divu, 0 = multu (sampled with start)
//   flush      abort a running operation, hi/lo untouched
//   a, b       operands (sampled with start)
//   busy       operation in progress (MUL or DIV)
//   done       final cycle after an operation (DONE)
//   hi, lo     result registers
// ----------------------------------------------------------------------------
module mdu_iter
   import alu_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   mdu_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // acc: partial product high half (mul) / partial remainder (div)
   // wrk: multiplier shifting out (mul) / dividend->quotient (div)
   // opnd: multiplicand (mul) / divisor (div)
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] wrk_q, wrk_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;
   logic [WIDTH-1:0] iter_acc;
   logic [WIDTH-1:0] iter_wrk;

   // One iteration of either algorithm. After WIDTH steps acc/wrk hold
   // {hi,lo} of the product, or {remainder,quotient} of the division.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {acc_q, wrk_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opnd_q};
      // Difference fits in WIDTH bits whenever div_ge holds
      div_sub   = div_shift[WIDTH-1:0] - opnd_q;
      if (state_q == DIV) begin
         iter_acc = div_ge ? div_sub : div_shift[WIDTH-1:0];
         iter_wrk = {wrk_q[WIDTH-2:0], div_ge};
      end else begin
         iter_acc = mul_sum[WIDTH:1];
         iter_wrk = {mul_sum[0], wrk_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      wrk_d   = wrk_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               cnt_d   = '0;
               opnd_d  = is_div ? b : a;
               wrk_d   = is_div ? a : b;
               state_d = is_div ? DIV : MUL;
            end
         end
         MUL, DIV: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               acc_d = iter_acc;
               wrk_d = iter_wrk;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  hi_d    = iter_acc;
                  lo_d    = iter_wrk;
                  state_d = DONE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         wrk_q   <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         wrk_q   <= wrk_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == MUL) || (state_q == DIV);
   assign done = (state_q == DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// EX-stage ALU: decodes alu_type/func, computes combinational results and
// drives the iterative multiply/divide unit, stalling the pipeline while it
// runs.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   valid              EX holds a valid instruction
//   flush              squash EX instruction, abort MDU operation
//   alu_type, func     operation select
//   a, b               operands
//   result, zero       ALU / mfhi / mflo result and its zero flag
//   alu_op             decoded operation code
//   illegal            unsupported R-type func
//   stall              hold the pipeline (MDU start or busy)
//   hi, lo             MDU result registers
// ----------------------------------------------------------------------------
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic             flush,
   input  logic [1:0]       alu_type,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [2:0]       alu_op,
   output logic             illegal,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic             is_mdu;
   logic             is_div;
   logic             sel_hi;
   logic             sel_lo;
   logic             sel_zero;
   logic [WIDTH-1:0] alu_res;
   logic             start;
   logic             busy;
   logic             done;

   // Decode
   always_comb begin
      alu_op   = OP_ADD;
      illegal  = 1'b0;
      is_mdu   = 1'b0;
      is_div   = 1'b0;
      sel_hi   = 1'b0;
      sel_lo   = 1'b0;
      sel_zero = 1'b0;
      unique case (alu_type)
         ALU_TYPE_ADD: alu_op = OP_ADD;
         ALU_TYPE_SUB: alu_op = OP_SUB;
         ALU_TYPE_AND: alu_op = OP_AND;
         ALU_TYPE_RTYPE: begin
            case (func)
               FUNC_ADD:   alu_op = OP_ADD;
               FUNC_SUB:   alu_op = OP_SUB;
               FUNC_SLT:   alu_op = OP_SLT;
               FUNC_SLTU:  alu_op = OP_SLTU;
               FUNC_AND:   alu_op = OP_AND;
               FUNC_OR:    alu_op = OP_OR;
               FUNC_XOR:   alu_op = OP_XOR;
               FUNC_NOR:   alu_op = OP_NOR;
               FUNC_MFHI:  sel_hi = 1'b1;
               FUNC_MFLO:  sel_lo = 1'b1;
               FUNC_MULTU: begin
                  is_mdu   = 1'b1;
                  sel_zero = 1'b1;
               end
               FUNC_DIVU: begin
                  is_mdu   = 1'b1;
                  is_div   = 1'b1;
                  sel_zero = 1'b1;
               end
               default: begin
                  illegal  = 1'b1;
                  sel_zero = 1'b1;
               end
            endcase
         end
         default: alu_op = OP_ADD;
      endcase
   end

   // Combinational ALU
   always_comb begin
      alu_res = '0;
      case (alu_op)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SUB:  alu_res = a - b;
         OP_SLT:  alu_res[0] = $signed(a) < $signed(b);
         OP_SLTU: alu_res[0] = a < b;
         default: alu_res = a + b;
      endcase
   end

   always_comb begin
      if (sel_hi) begin
         result = hi;
      end else if (sel_lo) begin
         result = lo;
      end else if (sel_zero) begin
         result = '0;
      end else begin
         result = alu_res;
      end
   end

   assign zero = (result == '0);

   // DONE must not re-launch: the finished multu/divu is still sitting in EX.
   // Reset is folded in so stall is low for the whole reset interval.
   assign start = rst & valid & ~flush & is_mdu & ~busy & ~done;
   assign stall = start | busy;

   mdu_iter #(
      .WIDTH (WIDTH)
   ) u_mdu_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .is_div (is_div),
      .flush  (flush),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit (WIDTH = 32). Expected values come
// from a behavioural model using plain arithmetic on the operands.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;
   import alu_pkg::*;

   localparam int unsigned W = 32;
   localparam int STALL_CYCLES = W + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid;
   logic          flush;
   logic [1:0]    alu_type;
   logic [5:0]    func;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [W-1:0]  result;
   logic          zero;
   logic [2:0]    alu_op;
   logic          illegal;
   logic          stall;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  exp_hi;
   logic [W-1:0]  exp_lo;

   alu_exec_unit #(
      .WIDTH (W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .valid    (valid),
      .flush    (flush),
      .alu_type (alu_type),
      .func     (func),
      .a        (a),
      .b        (b),
      .result   (result),
      .zero     (zero),
      .alu_op   (alu_op),
      .illegal  (illegal),
      .stall    (stall),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   // Reference model: combinational result, op code and illegal flag
   function automatic void ref_alu(input logic [1:0] t, input logic [5:0] f,
                                   input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] h, input logic [W-1:0] l,
                                   output logic [W-1:0] r, output logic [2:0] op,
                                   output logic ill);
      r   = '0;
      op  = 3'b010;
      ill = 1'b0;
      if (t == 2'b00) begin
         r = x + y;
      end else if (t == 2'b01) begin
         r = x - y; op = 3'b110;
      end else if (t == 2'b11) begin
         r = x & y; op = 3'b000;
      end else begin
         case (f)
            FUNC_ADD:  r = x + y;
            FUNC_SUB:  begin r = x - y; op = 3'b110; end
            FUNC_SLT:  begin r = ($signed(x) < $signed(y)) ? 1 : 0; op = 3'b111; end
            FUNC_SLTU: begin r = (x < y) ? 1 : 0; op = 3'b101; end
            FUNC_AND:  begin r = x & y; op = 3'b000; end
            FUNC_OR:   begin r = x | y; op = 3'b001; end
            FUNC_XOR:  begin r = x ^ y; op = 3'b011; end
            FUNC_NOR:  begin r = ~(x | y); op = 3'b100; end
            FUNC_MFHI: r = h;
            FUNC_MFLO: r = l;
            FUNC_MULTU, FUNC_DIVU: r = '0;
            default:   ill = 1'b1;
         endcase
      end
   endfunction

   // Reference model: multu / divu results
   function automatic void ref_mdu(input bit div, input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
      logic [2*W-1:0] p;
      if (div) begin
         if (y == 0) begin
            l = '1; h = x;
         end else begin
            l = x / y; h = x % y;
         end
      end else begin
         p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
         h = p[2*W-1:W];
         l = p[W-1:0];
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue multu/divu and count stall-high cycles; returns in the cycle stall
   // first drops (or after 200 cycles, which the caller sees as a bad count).
   task automatic run_mdu(input bit div, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int ncyc);
      valid    = 1'b1;
      flush    = 1'b0;
      alu_type = ALU_TYPE_RTYPE;
      func     = div ? FUNC_DIVU : FUNC_MULTU;
      a        = x;
      b        = y;
      #1;
      ncyc = 0;
      while (stall === 1'b1 && ncyc < 200) begin
         ncyc++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; valid = 1'b1; flush = 1'b0;
      alu_type = ALU_TYPE_RTYPE; func = FUNC_MFHI;
      a = $urandom; b = $urandom;
      #2;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (stall !== 1'b0 || hi !== '0 || lo !== '0 || result !== '0) begin
            errors++;
            $display("FAIL reset: stall=%b hi=%h lo=%h result=%h, want 0/0/0/0",
                     stall, hi, lo, result);
         end
         tick();
      end
      rst = 1'b1;
      tick();
      checks++;
      if (stall !== 1'b0 || result !== '0) begin
         errors++;
         $display("FAIL reset_release: stall=%b result=%h, want 0/0", stall, result);
      end
      exp_hi = '0; exp_lo = '0;
   endtask

   task automatic test_comb_directed();
      logic [1:0]   t_tab [4] = '{2'b10, 2'b10, 2'b01, 2'b10};
      logic [5:0]   f_tab [4] = '{FUNC_SLT, FUNC_SLTU, FUNC_ADD, FUNC_NOR};
      logic [W-1:0] a_tab [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd5, 32'd0};
      logic [W-1:0] b_tab [4] = '{32'd2, 32'd2, 32'd5, 32'd0};
      logic [W-1:0] r_tab [4] = '{32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF};
      logic         z_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0]   o_tab [4] = '{3'b111, 3'b101, 3'b110, 3'b100};
      valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alu_type = t_tab[i]; func = f_tab[i]; a = a_tab[i]; b = b_tab[i];
         #1;
         checks++;
         if (result !== r_tab[i] || zero !== z_tab[i] || alu_op !== o_tab[i]
             || stall !== 1'b0) begin
            errors++;
            $display("FAIL comb_directed[%0d]: result=%h zero=%b op=%b stall=%b, want %h/%b/%b/0",
                     i, result, zero, alu_op, stall, r_tab[i], z_tab[i], o_tab[i]);
         end
         tick();
      end
   endtask

   task automatic test_comb_random();
      logic [5:0]   f_list [11] = '{FUNC_ADD, FUNC_SUB, FUNC_SLT, FUNC_SLTU, FUNC_AND,
                                    FUNC_OR, FUNC_XOR, FUNC_NOR, FUNC_MFHI, FUNC_MFLO,
                                    6'b111111};
      logic [W-1:0] er;
      logic [2:0]   eop;
      logic         eill;
      for (int i = 0; i < 40; i++) begin
         valid    = 1'($urandom_range(0, 1));
         alu_type = 2'($urandom_range(0, 3));
         func     = f_list[$urandom_range(0, 10)];
         a        = $urandom;
         b        = ($urandom_range(0, 3) == 0) ? a : $urandom;
         #1;
         ref_alu(alu_type, func, a, b, exp_hi, exp_lo, er, eop, eill);
         checks++;
         if (result !== er || zero !== (er == 0) || alu_op !== eop || illegal !== eill
             || stall !== 1'b0) begin
            errors++;
            $display("FAIL comb_random[%0d] t=%b f=%b a=%h b=%h: result=%h z=%b op=%b ill=%b stall=%b, want %h/%b/%b/%b/0",
                     i, alu_type, func, a, b, result, zero, alu_op, illegal, stall,
                     er, (er == 0), eop, eill);
         end
         tick();
      end
   endtask

   task automatic test_multu();
      int n;
      run_mdu(1'b0, 32'hFFFF_FFFF, 32'd2, n);
      ref_mdu(1'b0, 32'hFFFF_FFFF, 32'd2, exp_hi, exp_lo);
      checks++;
      if (n !== STALL_CYCLES || hi !== 32'h1 || lo !== 32'hFFFF_FFFE || exp_lo !== lo) begin
         errors++;
         $display("FAIL multu: stall_cycles=%0d hi=%h lo=%h, want %0d/00000001/fffffffe",
                  n, hi, lo, STALL_CYCLES);
      end
      tick();
      func = FUNC_MFLO;
      #1;
      checks++;
      if (result !== 32'hFFFF_FFFE || stall !== 1'b0) begin
         errors++;
         $display("FAIL mflo_after_multu: result=%h stall=%b, want fffffffe/0", result, stall);
      end
      tick();
   endtask

   task automatic test_divu();
      int n;
      run_mdu(1'b1, 32'd100, 32'd7, n);
      checks++;
      if (n !== STALL_CYCLES || lo !== 32'd14 || hi !== 32'd2) begin
         errors++;
         $display("FAIL divu: stall_cycles=%0d hi=%0d lo=%0d, want %0d/2/14",
                  n, hi, lo, STALL_CYCLES);
      end
      valid = 1'b0;
      tick();
      run_mdu(1'b1, 32'd5, 32'd0, n);
      checks++;
      if (n !== STALL_CYCLES || lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
         errors++;
         $display("FAIL divu_by_zero: stall_cycles=%0d hi=%h lo=%h, want %0d/00000005/ffffffff",
                  n, hi, lo, STALL_CYCLES);
      end
      exp_hi = 32'd5; exp_lo = 32'hFFFF_FFFF;
      valid = 1'b0;
      tick();
   endtask

   task automatic test_flush_abort();
      int n;
      // 79 / 8 leaves hi=7, lo=9
      run_mdu(1'b1, 32'd79, 32'd8, n);
      checks++;
      if (n !== STALL_CYCLES || hi !== 32'd7 || lo !== 32'd9) begin
         errors++;
         $display("FAIL flush_preset: stall_cycles=%0d hi=%0d lo=%0d, want %0d/7/9",
                  n, hi, lo, STALL_CYCLES);
      end
      exp_hi = 32'd7; exp_lo = 32'd9;
      valid = 1'b0;
      tick();
      valid = 1'b1; alu_type = ALU_TYPE_RTYPE; func = FUNC_MULTU; a = 32'd3; b = 32'd4;
      for (int i = 0; i < 10; i++) tick();
      flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_busy: stall=%b in busy cycle 10, want 1", stall);
      end
      tick();
      flush = 1'b0; valid = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || hi !== 32'd7 || lo !== 32'd9) begin
         errors++;
         $display("FAIL flush_abort: stall=%b hi=%0d lo=%0d, want 0/7/9", stall, hi, lo);
      end
      tick();
   endtask

   task automatic test_reset_abort();
      valid = 1'b1; flush = 1'b0; alu_type = ALU_TYPE_RTYPE; func = FUNC_MULTU;
      a = 32'd3; b = 32'd4;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b0; valid = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || hi !== '0 || lo !== '0) begin
         errors++;
         $display("FAIL reset_abort: stall=%b hi=%h lo=%h, want 0/0/0", stall, hi, lo);
      end
      tick();
      rst = 1'b1;
      exp_hi = '0; exp_lo = '0;
      tick();
      checks++;
      if (stall !== 1'b0 || hi !== '0 || lo !== '0) begin
         errors++;
         $display("FAIL reset_abort_idle: stall=%b hi=%h lo=%h, want 0/0/0", stall, hi, lo);
      end
   endtask

   task automatic test_illegal();
      valid = 1'b1; alu_type = ALU_TYPE_RTYPE; func = 6'b111111;
      a = $urandom; b = $urandom;
      #1;
      checks++;
      if (illegal !== 1'b1 || result !== '0 || stall !== 1'b0 || alu_op !== 3'b010) begin
         errors++;
         $display("FAIL illegal: ill=%b result=%h stall=%b op=%b, want 1/0/0/010",
                  illegal, result, stall, alu_op);
      end
      tick();
      checks++;
      if (stall !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
         errors++;
         $display("FAIL illegal_no_state: stall=%b hi=%h lo=%h, want 0/%h/%h",
                  stall, hi, lo, exp_hi, exp_lo);
      end
      valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int           n;
      bit           div;
      logic [W-1:0] x;
      logic [W-1:0] y;
      for (int i = 0; i < 6; i++) begin
         div = 1'($urandom_range(0, 1));
         x   = $urandom;
         case ($urandom_range(0, 3))
            0:       y = '0;
            1:       y = W'($urandom_range(1, 300));
            default: y = $urandom;
         endcase
         run_mdu(div, x, y, n);
         ref_mdu(div, x, y, exp_hi, exp_lo);
         checks++;
         if (n !== STALL_CYCLES || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL back_to_back[%0d] div=%0d a=%h b=%h: cycles=%0d hi=%h lo=%h, want %0d/%h/%h",
                     i, div, x, y, n, hi, lo, STALL_CYCLES, exp_hi, exp_lo);
         end
         tick();
         func = FUNC_MFHI;
         #1;
         checks++;
         if (result !== exp_hi || stall !== 1'b0) begin
            errors++;
            $display("FAIL mfhi_after[%0d]: result=%h stall=%b, want %h/0",
                     i, result, stall, exp_hi);
         end
         tick();
      end
      valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_comb_directed();
      test_multu();
      test_divu();
      test_comb_random();
      test_flush_abort();
      test_reset_abort();
      test_illegal();
      test_back_to_back();
      test_comb_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised EX-stage successor to the pipeline's ALU decode logic. Decodes alu_type/func into an ALU operation and computes the result.
- Adds an iterative unsigned multiply/divide unit (MDU) with HI/LO registers. The MDU stalls the pipeline while it is busy.
- Sits between the ID/EX register and the EX/MEM register. The hazard unit consumes the stall output.

Parameters:
- WIDTH, 32, datapath width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid  in  1  EX stage holds a valid instruction.
- flush  in  1  squash the EX instruction and abort any MDU operation.
- alu_type  in  2  00 add (lw/sw/addi), 01 sub (beq/bne), 10 R-type by func, 11 and (andi).
- func  in  6  R-type function field.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or immediate).
- result  out  WIDTH  ALU / mfhi / mflo result.
- zero  out  1  result == 0.
- alu_op  out  3  decoded op: 010 add, 110 sub, 111 slt, 000 and, 001 or, 011 xor, 100 nor, 101 sltu.
- illegal  out  1  alu_type=10 with an unsupported func.
- stall  out  1  hold the pipeline (MDU start or busy).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- R-type funcs:
  - 100000 add; 100010 sub; 101010 slt (signed); 101011 sltu; 100100 and; 100101 or; 100110 xor; 100111 nor.
  - 011001 multu; 011011 divu; 010000 mfhi; 010010 mflo.
- Combinational ops have zero latency; result, zero, alu_op and illegal are purely combinational.
- mfhi/mflo return the current hi/lo. For multu/divu/illegal, result=0 and alu_op=010.
- Add/sub wrap modulo 2^WIDTH; no overflow trap. slt/sltu return 1 or 0, zero-extended.
- Reset (rst low, asynchronous): state=IDLE, hi=lo=0, counter=0, stall=0. Reset mid-operation discards the operation.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: start = valid & !flush & alu_type==10 & func in {multu, divu}. On start, stall=1 combinationally in the same cycle; latch a and b, counter=0; go to MUL or DIV.
  - MUL/DIV: one shift-add (mul) or restoring shift-subtract (div) iteration per cycle; stall=1. After iteration WIDTH-1, write hi/lo and go to DONE.
  - DONE: stall=0, start ignored (the same instruction is still in EX); return to IDLE next cycle.
- Timing: start in cycle T; iterations in cycles T+1..T+WIDTH; hi/lo visible from T+WIDTH+1. Stall is high for exactly WIDTH+1 cycles.
- multu: {hi,lo} = a*b, full 2*WIDTH-bit unsigned product.
- divu: lo = a/b, hi = a%b. Divide by zero takes the same WIDTH cycles and yields lo = all ones, hi = a; no exception.
- flush in MUL/DIV: return to IDLE next cycle, hi/lo unchanged, stall low from that next cycle. flush in IDLE blocks start.
- valid is ignored while in MUL/DIV; the pipeline is stalled and the inputs are held.
- An instruction following multu/divu that reads hi/lo sees the new values because of the DONE sequencing; no forwarding is needed.

Decomposition:
- Shared package alu_pkg:
  - alu_type codes, func codes and alu_op codes as localparams.
  - mdu_state_t enum {IDLE, MUL, DIV, DONE}.
- Sub-module mdu_iter: FSM, counter, working registers and hi/lo, with ports start, is_div, flush, a, b → busy, done, hi, lo.
- alu_exec_unit contains the decode, the combinational ALU and the result mux; stall = start | busy.

Test Plan:
- Reset: hold rst=0 with func=mfhi, alu_type=10 → stall=0, hi=lo=0, result=0. Release rst → state IDLE.
- Combinational ops:
  - slt, a=0xFFFFFFFD, b=2 → result=1; sltu with the same operands → 0.
  - alu_type=01, a=b=5 → result=0, zero=1, alu_op=110.
  - nor, a=0, b=0 → 0xFFFFFFFF.
- multu, a=0xFFFFFFFF, b=2 → stall high 33 cycles, then one DONE cycle with stall=0; hi=0x00000001, lo=0xFFFFFFFE. A following mflo → result=0xFFFFFFFE.
- divu:
  - a=100, b=7 → lo=14, hi=2 after 33 stall cycles.
  - a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- Abort:
  - Start multu (a=3, b=4) after hi/lo hold 7/9; assert flush in busy cycle 10 → stall=0 next cycle, hi=7, lo=9, state IDLE.
  - Repeat with rst pulsed low instead of flush → hi=lo=0.
- Illegal: alu_type=10, func=111111, valid=1 → illegal=1, result=0, stall=0, no state change.
